alu_seqdec: RTL and testbench
=============================

# alu_seqdec

Parametrised successor to the combinational ALU decoder. It decodes `aluop`/`funct` into the 4-bit ALU control word and runs multi-cycle MULT/DIV on an iterative WIDTH-bit engine that owns the HI/LO result registers. It sits in the execute stage and raises `stall` to freeze the pipeline while a multiply or divide is in flight.

## Interface

Parameters:
- `WIDTH`, 32: operand width for the multiply/divide engine; HI/LO are each WIDTH bits.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `valid`  in  1  execute stage holds a live instruction
- `flush`  in  1  synchronous abort of any in-flight MULT/DIV
- `aluop`  in  2  main-decoder ALU op class
- `funct`  in  6  R-type function field
- `srca`  in  WIDTH  multiplicand / dividend
- `srcb`  in  WIDTH  multiplier / divisor
- `alucontrol`  out  4  decoded ALU control, combinational
- `illegal`  out  1  `aluop` = 11, or R-type with an unknown `funct`
- `stall`  out  1  hold the pipeline
- `done`  out  1  one-cycle pulse when HI/LO update
- `hi`  out  WIDTH  product upper half / remainder
- `lo`  out  WIDTH  product lower half / quotient

## Operation

Decode is combinational and independent of state.
- `aluop` 00 → ADD 0010.
- `aluop` 01 → SUB 0110.
- `aluop` 10, by `funct`:
  - 100000 → ADD 0010
  - 100010 → SUB 0110
  - 100100 → AND 0000
  - 100101 → OR 0001
  - 010010 → SLL 0011
  - 010000 → SRL 0100
  - 100111 → NOT 0101
  - 011000 → MULT 0111
  - 101010 → DIV 1000
- Any other `funct`, or `aluop` 11 → INVALID 1111, with `illegal` = 1.

Sequencer FSM with states IDLE, BUSY, DONE:
- Accept condition: state IDLE, `valid`=1, `flush`=0, and `alucontrol` is MULT or DIV.
- On accept, latch operands and op, set iteration count to WIDTH, and move to BUSY.
- DIV with `srcb`=0 skips BUSY and goes straight to DONE with `lo` = all ones and `hi` = `srca`.
- BUSY performs one iteration per cycle:
  - MULT: unsigned shift-add.
  - DIV: unsigned restoring.
  - When the count reaches 0, write HI/LO and move to DONE.
- DONE asserts `done`, inputs are ignored, and the next state is always IDLE. A back-to-back MULT/DIV is therefore accepted no sooner than the cycle after DONE.
- MULT result: the 2·WIDTH unsigned product; `hi` = upper half, `lo` = lower half.
- DIV result: `lo` = quotient, `hi` = remainder, both unsigned.
- `flush` forces IDLE from any state; HI/LO are left unchanged and `done` is not pulsed. If `flush` coincides with an accept, `flush` wins.
- `hi`/`lo` hold their value until the next DONE.
- A non-MULT/DIV op never touches the sequencer.

## Timing

Reset:
- `reset_n` low clears state to IDLE, the iteration count to 0, and `hi`, `lo`, `done` to 0 immediately.
- `stall` is 0 during reset.
- Reset mid-operation abandons the operation entirely; no result is written.

Stall and done:
- `stall` = (IDLE ∧ accept condition) ∨ BUSY. It is combinational so the pipeline freezes in the accept cycle itself.
- Latency with the accept edge as E0:
  - Iterations occur on edges E1 through E_WIDTH.
  - HI/LO are written on E_WIDTH.
  - `done` is high during the cycle after E_WIDTH.
- `stall` is high for WIDTH+1 cycles and low during DONE, so the instruction retires at the DONE edge.
- Divide by zero: `stall` is high for 1 cycle, and `done` is high in the cycle after E0.
- `valid` dropping during BUSY has no effect; only `flush` aborts.

## Structure

- Package `alu_pkg` holds:
  - the `alucontrol_t` enum with the ten codes above;
  - funct localparams `F_ADD`…`F_DIV`;
  - the `aluop` localparams;
  - the `md_state_t` enum (IDLE, BUSY, DONE).
- Sub-module `muldiv_iter`, parametrised by WIDTH, holds the operand/accumulator registers and the per-cycle shift-add and restoring-subtract step.
- `alu_seqdec` holds the decode logic, the FSM, the counter and the HI/LO registers.

## Test plan

All cases use WIDTH=32.

1. Decode sweep:
   - `aluop` 00 → 0010; `aluop` 01 → 0110.
   - `aluop` 10 with each of the nine functs → its code from the list above.
   - `funct` 111111 → 1111 with `illegal`=1; `aluop` 11 → 1111 with `illegal`=1.
   - Stall stays 0 throughout.
2. MULT 0xFFFFFFFF × 2:
   - `stall` is high for 33 cycles.
   - `done` pulses in cycle 33 after accept.
   - `hi`=0x00000001, `lo`=0xFFFFFFFE.
3. DIV 100 ÷ 7:
   - `lo`=14, `hi`=2 at `done`.
   - A second DIV presented in the cycle after DONE is accepted, and `stall` rises again.
4. DIV 5 ÷ 0:
   - `stall` is high for 1 cycle, and `done` is high the next cycle.
   - `lo`=0xFFFFFFFF, `hi`=5.
5. MULT 3 × 4 with `flush` on cycle 10:
   - Returns to IDLE with no `done`.
   - `hi`/`lo` retain the test-3 values (2 and 14).
6. MULT in flight with `reset_n` pulsed low asynchronously mid-cycle:
   - `stall`, `done`, `hi`, `lo` go to 0 immediately.
   - After release, a new MULT 6 × 7 gives `lo`=42, `hi`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the execute-stage ALU decoder and its
// multi-cycle multiply/divide sequencer.
//   alucontrol_t : 4-bit ALU control codes driven to the datapath
//   F_*          : R-type funct field encodings
//   AOP_*        : main-decoder aluop classes
//   md_state_t   : MULT/DIV sequencer states
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SLL     = 4'b0011,
        ALU_SRL     = 4'b0100,
        ALU_NOT     = 4'b0101,
        ALU_SUB     = 4'b0110,
        ALU_MULT    = 4'b0111,
        ALU_DIV     = 4'b1000,
        ALU_INVALID = 4'b1111
    } alucontrol_t;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLL  = 6'b010010;
    localparam logic [5:0] F_SRL  = 6'b010000;
    localparam logic [5:0] F_NOT  = 6'b100111;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b101010;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One iteration per cycle while step is high; WIDTH iterations complete an op.
//   clk, reset_n      : clock, asynchronous active-low reset
//   load              : capture operands and op (overrides step)
//   load_div          : 1 = divide, 0 = multiply (sampled with load)
//   load_a, load_b    : multiplicand/dividend, multiplier/divisor
//   step              : perform one iteration this cycle
//   nxt_hi, nxt_lo    : result of the current iteration (product halves, or
//                       remainder/quotient after the final iteration)
// -----------------------------------------------------------------------------
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             load_div,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    input  logic             step,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    // acc_hi: partial product upper half / partial remainder
    // acc_lo: multiplier being shifted out / dividend shifting into quotient
    // opnd  : multiplicand / divisor
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q,   opnd_d;
    logic             div_q,    div_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

    always_comb begin
        // Multiply: add multiplicand when LSB of multiplier is set, then shift
        // the whole {carry, acc_hi, acc_lo} right by one.
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the remainder and subtract
        // the divisor if it fits. The remainder after subtraction is always
        // below the divisor, so only the low WIDTH bits of the difference matter.
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        if (div_shift >= {1'b0, opnd_q}) begin
            div_hi = div_shift[WIDTH-1:0] - opnd_q;
            div_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_hi = div_shift[WIDTH-1:0];
            div_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
        end

        nxt_hi = div_q ? div_hi : mul_hi;
        nxt_lo = div_q ? div_lo : mul_lo;
    end

    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        if (load) begin
            acc_hi_d = '0;
            acc_lo_d = load_div ? load_a : load_b;
            opnd_d   = load_div ? load_b : load_a;
            div_d    = load_div;
        end else if (step) begin
            acc_hi_d = nxt_hi;
            acc_lo_d = nxt_lo;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            div_q    <= div_d;
        end
    end

endmodule

// File: rtl/alu_seqdec.sv
// -----------------------------------------------------------------------------
// alu_seqdec
// Execute-stage ALU control decoder with a multi-cycle MULT/DIV sequencer that
// owns the HI/LO result registers and stalls the pipeline while busy.
//   clk, reset_n : clock, asynchronous active-low reset
//   valid, flush : live instruction in execute / abort in-flight MULT/DIV
//   aluop, funct : decode inputs
//   srca, srcb   : multiplicand/dividend, multiplier/divisor
//   alucontrol   : decoded control word (combinational)
//   illegal      : reserved aluop or unknown R-type funct
//   stall        : freeze pipeline (accept cycle and every BUSY cycle)
//   done         : one-cycle pulse in the cycle HI/LO hold a new result
//   hi, lo       : product upper/lower half, or remainder/quotient
// -----------------------------------------------------------------------------
module alu_seqdec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic             flush,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [3:0]       alucontrol,
    output logic             illegal,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    alucontrol_t      ctl;
    md_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             is_md, accept, div_by_zero;
    logic             eng_load, eng_step;
    logic [WIDTH-1:0] eng_hi, eng_lo;

    // ---------------- decode ----------------
    always_comb begin
        ctl     = ALU_INVALID;
        illegal = 1'b0;
        case (aluop)
            AOP_ADD:   ctl = ALU_ADD;
            AOP_SUB:   ctl = ALU_SUB;
            AOP_RTYPE: begin
                case (funct)
                    F_ADD:   ctl = ALU_ADD;
                    F_SUB:   ctl = ALU_SUB;
                    F_AND:   ctl = ALU_AND;
                    F_OR:    ctl = ALU_OR;
                    F_SLL:   ctl = ALU_SLL;
                    F_SRL:   ctl = ALU_SRL;
                    F_NOT:   ctl = ALU_NOT;
                    F_MULT:  ctl = ALU_MULT;
                    F_DIV:   ctl = ALU_DIV;
                    default: begin
                        ctl     = ALU_INVALID;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                ctl     = ALU_INVALID;
                illegal = 1'b1;
            end
        endcase
        alucontrol = ctl;
    end

    // Accept is gated by reset_n so stall stays low while reset is held.
    always_comb begin
        is_md       = (ctl == ALU_MULT) || (ctl == ALU_DIV);
        accept      = reset_n && (state_q == MD_IDLE) && valid && !flush && is_md;
        div_by_zero = (ctl == ALU_DIV) && (srcb == '0);
    end

    // ---------------- engine ----------------
    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (eng_load),
        .load_div (ctl == ALU_DIV),
        .load_a   (srca),
        .load_b   (srcb),
        .step     (eng_step),
        .nxt_hi   (eng_hi),
        .nxt_lo   (eng_lo)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        eng_load = 1'b0;
        eng_step = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    if (div_by_zero) begin
                        state_d = MD_DONE;
                        cnt_d   = '0;
                        hi_d    = srca;
                        lo_d    = '1;
                    end else begin
                        state_d  = MD_BUSY;
                        cnt_d    = CW'(WIDTH);
                        eng_load = 1'b1;
                    end
                end
            end
            MD_BUSY: begin
                eng_step = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                // Final iteration: capture the engine's step result directly.
                if (cnt_q == CW'(1)) begin
                    hi_d    = eng_hi;
                    lo_d    = eng_lo;
                    state_d = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        stall = accept || (state_q == MD_BUSY);
        done  = (state_q == MD_DONE);
        hi    = hi_q;
        lo    = lo_q;
    end

endmodule

// File: tb/tb_alu_seqdec.sv
// -----------------------------------------------------------------------------
// tb_alu_seqdec
// Directed + randomized bench for alu_seqdec (WIDTH=32). Expected results come
// from a decode lookup table and plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_seqdec;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset_n;
    logic         valid;
    logic         flush;
    logic [1:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic [3:0]   alucontrol;
    logic         illegal;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int unsigned  vectors     = 0;
    int unsigned  miscompares = 0;
    logic [W-1:0] exp_hi      = '0;
    logic [W-1:0] exp_lo      = '0;

    logic [5:0]   fn_tab [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h12, 6'h10, 6'h27, 6'h18, 6'h2a};
    logic [3:0]   cd_tab [9] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8};

    alu_seqdec #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (valid),
        .flush      (flush),
        .aluop      (aluop),
        .funct      (funct),
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {illegal, code}
    function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return {1'b0, 4'h2};
        if (op == 2'b01) return {1'b0, 4'h6};
        if (op == 2'b11) return 5'h1f;
        for (int i = 0; i < 9; i++)
            if (f == fn_tab[i]) return {1'b0, cd_tab[i]};
        return 5'h1f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec_check(input logic [1:0] op, input logic [5:0] f, input string tag);
        logic [4:0] r;
        r     = ref_dec(op, f);
        aluop = op;
        funct = f;
        valid = (r[3:0] == 4'h7 || r[3:0] == 4'h8) ? 1'b0 : 1'b1;
        #1;
        chk({tag, " ctl"}, alucontrol, r[3:0]);
        chk({tag, " ill"}, illegal, r[4]);
        chk({tag, " stall"}, stall, 0);
        tick();
    endtask

    // Presents a MULT/DIV in an IDLE cycle and follows it to its DONE cycle.
    task automatic run_md(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        int unsigned n;
        logic [63:0] p;
        valid = 1'b1;
        flush = 1'b0;
        aluop = 2'b10;
        funct = is_div ? 6'h2a : 6'h18;
        srca  = a;
        srcb  = b;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
            valid = 1'b0;
            srca  = $urandom;
            srcb  = $urandom;
            #1;
        end
        if (is_div) begin
            if (b == 0) begin
                exp_hi = a;
                exp_lo = '1;
            end else begin
                exp_lo = a / b;
                exp_hi = a % b;
            end
        end else begin
            p      = {32'b0, a} * {32'b0, b};
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end
        chk({tag, " stall_cycles"}, 64'(n), (is_div && b == 0) ? 64'd1 : 64'(W + 1));
        chk({tag, " done"}, done, 1);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        int unsigned seen_done;
        logic        rd;
        logic [W-1:0] ra, rb;

        reset_n = 1'b0;
        valid   = 1'b0;
        flush   = 1'b0;
        aluop   = 2'b00;
        funct   = 6'h00;
        srca    = '0;
        srcb    = '0;
        #3;
        chk("rst stall", stall, 0);
        chk("rst done", done, 0);
        chk("rst hi", hi, 0);
        chk("rst lo", lo, 0);
        #20;
        reset_n = 1'b1;
        tick();

        // 1. decode sweep
        dec_check(2'b00, 6'h00, "dec aop00");
        dec_check(2'b01, 6'h00, "dec aop01");
        for (int i = 0; i < 9; i++) dec_check(2'b10, fn_tab[i], "dec rtype");
        dec_check(2'b10, 6'h3f, "dec f3f");
        dec_check(2'b11, 6'h20, "dec aop11");
        for (int i = 0; i < 30; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 1) == 1) ? fn_tab[$urandom_range(0, 8)] : 6'($urandom);
            dec_check(op, f, "dec rand");
        end

        // 4. divide by zero
        run_md(1'b1, 32'd5, 32'd0, "div5_0");
        chk("div5_0 lo const", lo, 32'hFFFFFFFF);
        chk("div5_0 hi const", hi, 32'd5);
        tick();
        chk("div5_0 done low", done, 0);

        // 2. MULT 0xFFFFFFFF x 2
        run_md(1'b0, 32'hFFFFFFFF, 32'd2, "mul_ff_2");
        chk("mul_ff_2 hi const", hi, 32'h00000001);
        chk("mul_ff_2 lo const", lo, 32'hFFFFFFFE);
        tick();
        chk("mul_ff_2 done low", done, 0);

        // 3. DIV 100/7, then a back-to-back DIV presented during DONE
        run_md(1'b1, 32'd100, 32'd7, "div100_7");
        chk("div100_7 lo const", lo, 32'd14);
        chk("div100_7 hi const", hi, 32'd2);
        valid = 1'b1;
        aluop = 2'b10;
        funct = 6'h2a;
        srca  = 32'd100;
        srcb  = 32'd7;
        #1;
        chk("b2b stall in done", stall, 0);
        tick();
        run_md(1'b1, 32'd100, 32'd7, "div_b2b");
        tick();
        chk("div_b2b done low", done, 0);

        // 5. MULT 3x4 flushed on cycle 10
        valid = 1'b1;
        aluop = 2'b10;
        funct = 6'h18;
        srca  = 32'd3;
        srcb  = 32'd4;
        #1;
        chk("flush accept stall", stall, 1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            valid = 1'b0;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush stall", stall, 0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        chk("flush no done", seen_done, 0);
        chk("flush hi kept", hi, exp_hi);
        chk("flush lo kept", lo, exp_lo);
        chk("flush hi const", hi, 32'd2);
        chk("flush lo const", lo, 32'd14);

        // randomized MULT/DIV
        for (int i = 0; i < 16; i++) begin
            rd = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = rd ? '0 : $urandom;
                1:       rb = W'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (i % 3 == 0) ra = W'($urandom_range(0, 1000));
            run_md(rd, ra, rb, rd ? "rand div" : "rand mul");
            tick();
            chk("rand done low", done, 0);
        end

        // 6. asynchronous reset in flight
        valid = 1'b1;
        aluop = 2'b10;
        funct = 6'h18;
        srca  = 32'hDEADBEEF;
        srcb  = 32'h12345678;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            valid = 1'b0;
        end
        #3;
        reset_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("arst stall", stall, 0);
        chk("arst done", done, 0);
        chk("arst hi", hi, exp_hi);
        chk("arst lo", lo, exp_lo);
        #12;
        reset_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        chk("arst abandoned done", seen_done, 0);
        chk("arst abandoned hi", hi, 0);
        chk("arst abandoned lo", lo, 0);
        run_md(1'b0, 32'd6, 32'd7, "mul6_7");
        chk("mul6_7 lo const", lo, 32'd42);
        chk("mul6_7 hi const", hi, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
